// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg: shared controller state encoding and depth helper.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int regfile_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_clear_fsm: CLEAR/RUN controller sweeping zeros through the   |
// | register array. Rev 1.0                                              |
// +----------------------------------------------------------------------+
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              ready
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    logic              r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ready <= (w_state_next == RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            CLEAR: begin
                if (i_clr) begin
                    w_idx_next = '0;
                end else if (r_idx == {ADDR_W{1'b1}}) begin
                    w_state_next = RUN;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            RUN: begin
                if (i_clr) begin
                    w_state_next = CLEAR;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = CLEAR;
                w_idx_next   = '0;
            end
        endcase
    end

    assign clear_we   = (r_state == CLEAR);
    assign clear_addr = r_idx;
    assign ready      = r_ready;

endmodule : regfile_clear_fsm
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_register_file: 1W/2R register file with sweep clear, write-    |
// | through bypass and registered read ports. Rev 1.0                    |
// +----------------------------------------------------------------------+
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clr,
    input  logic [DATA_W-1:0] W_data,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] Ra_addr,
    input  logic [ADDR_W-1:0] Rb_addr,
    input  logic              Ra_en,
    input  logic              Rb_en,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic              Ready,
    output logic              W_drop
);

    localparam int c_DEPTH = regfile_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_ra_data;
    logic [DATA_W-1:0] r_rb_data;
    logic              r_w_drop;

    logic              w_clear_we;
    logic [ADDR_W-1:0] w_clear_addr;
    logic              w_run;
    logic              w_zero_hit;
    logic              w_wr_acc;
    logic              w_drop;
    logic [DATA_W-1:0] w_ra_next;
    logic [DATA_W-1:0] w_rb_next;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk       (Clk),
        .rst       (Rst),
        .i_clr     (Clr),
        .clear_we  (w_clear_we),
        .clear_addr(w_clear_addr),
        .ready     (w_run)
    );

    // Writes to a hardwired-zero register vanish without being flagged.
    assign w_zero_hit = (ZERO_REG != 0) && (W_addr == '0);
    assign w_wr_acc   = !Rst && w_run && W_en && !Clr && !w_zero_hit;
    assign w_drop     = W_en && (!w_run || Clr) && !w_zero_hit;

    always_ff @(posedge Clk) begin
        if (w_clear_we) begin
            r_mem[w_clear_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[W_addr] <= W_data;
        end
    end

    assign w_ra_next = (!w_run || ((ZERO_REG != 0) && (Ra_addr == '0))) ? '0 :
                       (w_wr_acc && (W_addr == Ra_addr))                 ? W_data :
                                                                           r_mem[Ra_addr];
    assign w_rb_next = (!w_run || ((ZERO_REG != 0) && (Rb_addr == '0))) ? '0 :
                       (w_wr_acc && (W_addr == Rb_addr))                 ? W_data :
                                                                           r_mem[Rb_addr];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ra_data <= '0;
            r_rb_data <= '0;
            r_w_drop  <= 1'b0;
        end else begin
            if (Ra_en) r_ra_data <= w_ra_next;
            if (Rb_en) r_rb_data <= w_rb_next;
            r_w_drop <= w_drop;
        end
    end

    assign Ra_data = r_ra_data;
    assign Rb_data = r_rb_data;
    assign Ready   = w_run;
    assign W_drop  = r_w_drop;

endmodule : param_register_file
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_register_file: directed scoreboard bench for the register   |
// | file (ZERO_REG=0 and ZERO_REG=1 instances share stimulus). Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_param_register_file;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    localparam int SEL_RA    = 0;
    localparam int SEL_RB    = 1;
    localparam int SEL_READY = 2;
    localparam int SEL_DROP  = 3;
    localparam int SEL_Z_RA  = 4;
    localparam int SEL_Z_DRP = 5;
    localparam int SEL_Z_RDY = 6;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Clr;
    logic [DATA_W-1:0] W_data;
    logic [ADDR_W-1:0] W_addr;
    logic              W_en;
    logic [ADDR_W-1:0] Ra_addr;
    logic [ADDR_W-1:0] Rb_addr;
    logic              Ra_en;
    logic              Rb_en;
    logic [DATA_W-1:0] Ra_data, Rb_data, z_Ra_data, z_Rb_data;
    logic              Ready, W_drop, z_Ready, z_W_drop;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] model [DEPTH];
    logic [15:0] last_ra, last_rb;

    always #5 Clk = ~Clk;

    param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
        .Ra_addr(Ra_addr), .Rb_addr(Rb_addr), .Ra_en(Ra_en), .Rb_en(Rb_en),
        .Ra_data(Ra_data), .Rb_data(Rb_data), .Ready(Ready), .W_drop(W_drop)
    );

    param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
        .Clk(Clk), .Rst(Rst), .Clr(Clr), .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
        .Ra_addr(Ra_addr), .Rb_addr(Rb_addr), .Ra_en(Ra_en), .Rb_en(Rb_en),
        .Ra_data(z_Ra_data), .Rb_data(z_Rb_data), .Ready(z_Ready), .W_drop(z_W_drop)
    );

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_RA:    return Ra_data;
            SEL_RB:    return Rb_data;
            SEL_READY: return {15'd0, Ready};
            SEL_DROP:  return {15'd0, W_drop};
            SEL_Z_RA:  return z_Ra_data;
            SEL_Z_DRP: return {15'd0, z_W_drop};
            SEL_Z_RDY: return {15'd0, z_Ready};
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every expectation queued for it.
    task automatic step();
        exp_t        e;
        logic [15:0] obs;
        @(posedge Clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        Clr = 0; W_en = 0; Ra_en = 0; Rb_en = 0;
    endtask

    initial begin
        Rst = 1; idle_inputs();
        W_data = '0; W_addr = '0; Ra_addr = '0; Rb_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;

        // Reset: writes ignored, outputs cleared.
        W_en = 1; W_addr = 4'd2; W_data = 16'h1111; Ra_en = 1; Rb_en = 1;
        step();
        step();
        push("rst_ready", SEL_READY, 16'd0);
        push("rst_drop", SEL_DROP, 16'd0);
        push("rst_ra", SEL_RA, 16'd0);
        push("rst_rb", SEL_RB, 16'd0);
        step();

        // Sweep after reset: write during CLEAR is dropped; Ready rises on edge 16.
        Rst = 0; idle_inputs(); W_en = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 1) push("sweep_drop", SEL_DROP, 16'd1);
            if (i == 2) push("sweep_drop_end", SEL_DROP, 16'd0);
            push($sformatf("sweep_ready_%0d", i), SEL_READY, (i == DEPTH) ? 16'd1 : 16'd0);
            step();
            W_en = 0;
        end

        // All registers read zero.
        Ra_en = 1; Rb_en = 1;
        for (int a = 0; a < DEPTH; a++) begin
            Ra_addr = 4'(a); Rb_addr = 4'(DEPTH - 1 - a);
            push($sformatf("init_ra_%0d", a), SEL_RA, 16'h0000);
            push($sformatf("init_rb_%0d", a), SEL_RB, 16'h0000);
            step();
        end
        idle_inputs();

        // Write 0xBEEF to 5, then read on both ports.
        W_en = 1; W_addr = 4'd5; W_data = 16'hBEEF; model[5] = 16'hBEEF;
        push("wr5_drop", SEL_DROP, 16'd0);
        step();
        idle_inputs(); Ra_en = 1; Rb_en = 1; Ra_addr = 4'd5; Rb_addr = 4'd5;
        push("rd5_a", SEL_RA, 16'hBEEF);
        push("rd5_b", SEL_RB, 16'hBEEF);
        step();
        last_rb = 16'hBEEF;

        // A few more writes with random data, read back crosswise.
        idle_inputs();
        for (int a = 8; a < 12; a++) begin
            W_en = 1; W_addr = 4'(a); W_data = 16'($urandom); model[a] = W_data;
            step();
        end
        idle_inputs(); Ra_en = 1; Rb_en = 1;
        for (int a = 8; a < 12; a++) begin
            Ra_addr = 4'(a); Rb_addr = 4'(19 - a);
            push($sformatf("rnd_a_%0d", a), SEL_RA, model[a]);
            push($sformatf("rnd_b_%0d", a), SEL_RB, model[19 - a]);
            step();
            last_rb = model[19 - a];
        end

        // Bypass on A; B disabled holds.
        idle_inputs();
        W_en = 1; W_addr = 4'd3; W_data = 16'h1234; model[3] = 16'h1234;
        Ra_en = 1; Ra_addr = 4'd3; Rb_addr = 4'd3;
        push("byp_a", SEL_RA, 16'h1234);
        push("byp_b_hold", SEL_RB, last_rb);
        step();
        last_ra = 16'h1234;

        // Ra_en=0 holds while register 3 changes.
        idle_inputs();
        W_en = 1; W_addr = 4'd3; W_data = 16'h4321; model[3] = 16'h4321;
        push("hold_a", SEL_RA, last_ra);
        step();
        idle_inputs(); Rb_en = 1; Rb_addr = 4'd3;
        push("rd3_b", SEL_RB, 16'h4321);
        step();

        // ZERO_REG instance: write to 0 silently discarded.
        idle_inputs();
        W_en = 1; W_addr = 4'd0; W_data = 16'hFFFF; model[0] = 16'hFFFF;
        push("z_wr0_drop", SEL_Z_DRP, 16'd0);
        push("wr0_drop", SEL_DROP, 16'd0);
        step();
        idle_inputs(); Ra_en = 1; Ra_addr = 4'd0;
        push("z_rd0", SEL_Z_RA, 16'h0000);
        push("rd0", SEL_RA, 16'hFFFF);
        step();

        // Prepare address 7, then Clr collides with a write to it.
        idle_inputs();
        W_en = 1; W_addr = 4'd7; W_data = 16'hAAAA;
        step();
        idle_inputs();
        Clr = 1; W_en = 1; W_addr = 4'd7; W_data = 16'h5555;
        push("clr_drop", SEL_DROP, 16'd1);
        push("clr_ready", SEL_READY, 16'd0);
        step();
        idle_inputs();
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 3) begin
                Ra_en = 1; Ra_addr = 4'd5;
            end
            if (i == 4) begin
                push("clr_read_zero", SEL_RA, 16'h0000);
                Ra_en = 0;
            end
            if (i == 2) push("clr_drop_end", SEL_DROP, 16'd0);
            push($sformatf("clr_ready_%0d", i), SEL_READY, (i == DEPTH) ? 16'd1 : 16'd0);
            push($sformatf("z_clr_ready_%0d", i), SEL_Z_RDY, (i == DEPTH) ? 16'd1 : 16'd0);
            step();
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        idle_inputs(); Ra_en = 1; Rb_en = 1; Ra_addr = 4'd7; Rb_addr = 4'd5;
        push("post_clr_7", SEL_RA, model[7]);
        push("post_clr_5", SEL_RB, model[5]);
        step();

        // Rst mid-sweep restarts the full sweep.
        idle_inputs(); Clr = 1;
        step();
        Clr = 0;
        for (int i = 0; i < 7; i++) step();
        Rst = 1;
        step();
        push("midrst_ready", SEL_READY, 16'd0);
        step();
        Rst = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            push($sformatf("midrst_ready_%0d", i), SEL_READY, (i == DEPTH) ? 16'd1 : 16'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_param_register_file
`default_nettype wire

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bit width of every register and data port.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 reads as constant zero and ignores writes.
REQ-004 SHALL have port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port Clr, input, 1: runtime request to zero all registers.
REQ-007 SHALL have port W_data, input, DATA_W: write data.
REQ-008 SHALL have port W_addr, input, ADDR_W: write address.
REQ-009 SHALL have port W_en, input, 1: write enable.
REQ-010 SHALL have ports Ra_addr and Rb_addr, input, ADDR_W each: read addresses for ports A and B.
REQ-011 SHALL have ports Ra_en and Rb_en, input, 1 each: read enables for ports A and B.
REQ-012 SHALL have ports Ra_data and Rb_data, output, DATA_W each: registered read data, always driven and never high-Z.
REQ-013 SHALL have port Ready, output, 1: high when the file is accepting writes (not clearing).
REQ-014 SHALL have port W_drop, output, 1: one-cycle pulse marking a write that was discarded.

Function
REQ-015 Storage SHALL be a DEPTH x DATA_W array with no reset on the array, so it can be inferred as RAM; zeroing is done by a clear sweep.
REQ-016 The controller SHALL have two states, CLEAR and RUN.
- CLEAR: writes 0 to register idx; if idx == DEPTH-1, goes to RUN; otherwise idx increments.
- RUN: stays in RUN unless Clr=1, in which case it goes to CLEAR with idx=0.
REQ-017 Clr asserted during CLEAR SHALL restart the sweep at idx=0.
REQ-018 A full sweep SHALL take exactly DEPTH cycles; Ready SHALL equal (state == RUN) and is registered.
REQ-019 In RUN with W_en=1 and Clr=0, W_data SHALL be written to W_addr at the clock edge.
REQ-020 A write SHALL be discarded, with W_drop=1 on the next cycle, when:
- W_en=1 in CLEAR;
- W_en=1 in RUN together with Clr=1 (Clr has priority);
- ZERO_REG=1 and W_addr=0 (silently discarded in this case, W_drop stays 0).
REQ-021 Read latency SHALL be 1 cycle: with Ra_en=1 at edge k, Ra_data after edge k reflects Ra_addr sampled at edge k. Port B behaves identically and independently.
REQ-022 Write-through bypass: if an accepted write targets Ra_addr in the same cycle that Ra_en=1, Ra_data SHALL take W_data (new value), not the old contents. Port B likewise.
REQ-023 With Ra_en=0, Ra_data SHALL hold its previous value. Port B likewise.
REQ-024 A read in CLEAR state, or of address 0 when ZERO_REG=1, SHALL return 0.
REQ-025 Both ports reading the same address SHALL return identical data; no port conflict exists.

Reset
REQ-026 While Rst=1, at each edge:
- state <= CLEAR, idx <= 0;
- Ra_data, Rb_data <= 0;
- Ready <= 0, W_drop <= 0;
- W_en is ignored and W_drop is not asserted.
REQ-027 After Rst deasserts, the sweep SHALL run, and Ready SHALL rise exactly DEPTH cycles later. Rst mid-sweep SHALL restart the sweep.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the state enum (CLEAR, RUN) and the depth helper function.
REQ-029 The state machine plus idx counter SHALL be a sub-module regfile_clear_fsm (outputs: clear_we, clear_addr, ready). The array, bypass and read registers stay in param_register_file.

Verification
REQ-030 Reset then idle, defaults: Ready=0 for 16 cycles after Rst falls, then 1; reading all 16 addresses returns 0x0000.
REQ-031 Write/read: write 0xBEEF to address 5, then read A=5 and B=5 next cycle -> both 0xBEEF, 1 cycle after the read enable.
REQ-032 Bypass: in one cycle, W_addr=3, W_data=0x1234, W_en=1, Ra_addr=3, Ra_en=1 -> Ra_data=0x1234 the next cycle; Rb_en=0 -> Rb_data unchanged.
REQ-033 Clr collision: Clr=1 with W_en=1 to address 7 -> W_drop=1, Ready=0 for 16 cycles; address 7 reads 0 afterwards.
REQ-034 ZERO_REG=1: write 0xFFFF to address 0 -> W_drop=0; reading address 0 returns 0x0000.
REQ-035 Rst mid-sweep: assert Rst at sweep cycle 8 -> Ready rises exactly 16 cycles after Rst deasserts.
